// File: rtl/paddsb_pipe.sv
// paddsb_pipe: two-stage valid/ready packed saturating add/subtract unit.
// Each lane is a signed LANE_W-bit value. Every lane has its own adder,
// widened to LANE_W+1 bits, whose result is then either clamped (sat_en=1)
// or truncated (sat_en=0).
// Stage 1 holds the operands and mode. Stage 2 holds the packed result and
// the per-lane saturation flags.
module paddsb_pipe #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4,
  localparam int W     = LANE_W * LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic [LANES-1:0] sat_lane,
  input  logic             clr_sticky,
  output logic [LANES-1:0] sat_sticky
);

  // Stage 1: operands plus the mode bits, so the mode stays with its data.
  logic             r_s1_v;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic             r_s1_sub;
  logic             r_s1_sat;

  // Stage 2: finished result.
  logic             r_s2_v;
  logic [W-1:0]     r_sum;
  logic [LANES-1:0] r_sat_lane;
  logic [LANES-1:0] r_sat_sticky;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_out_hs;
  logic [W-1:0]     w_sum;
  logic [LANES-1:0] w_sat;

  // Stage 2 can load when it is empty or its result leaves this cycle.
  // Stage 1 can load when it is empty or its contents move into stage 2.
  // in_ready therefore depends combinationally on out_ready, so a full
  // pipeline can drain, advance and accept a new input in the same cycle.
  assign w_s2_load = !r_s2_v || out_ready;
  assign w_s1_load = !r_s1_v || w_s2_load;
  assign w_out_hs  = r_s2_v && out_ready;

  // Per-lane widened add/sub. Overflow of a LANE_W-bit signed result shows up
  // as a mismatch between the top two bits of the (LANE_W+1)-bit result.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0]     w_la;
    logic [LANE_W-1:0]     w_lb;
    logic signed [LANE_W:0] w_ea;
    logic signed [LANE_W:0] w_eb;
    logic signed [LANE_W:0] w_r;
    logic                  w_pos_ovf;
    logic                  w_neg_ovf;

    assign w_la = r_s1_a[g*LANE_W +: LANE_W];
    assign w_lb = r_s1_b[g*LANE_W +: LANE_W];
    assign w_ea = $signed({w_la[LANE_W-1], w_la});
    assign w_eb = $signed({w_lb[LANE_W-1], w_lb});
    assign w_r  = r_s1_sub ? (w_ea - w_eb) : (w_ea + w_eb);

    // Result sign bit 0 with a set bit LANE_W-1 means above the maximum;
    // the reverse means below the minimum.
    assign w_pos_ovf = !w_r[LANE_W] &&  w_r[LANE_W-1];
    assign w_neg_ovf =  w_r[LANE_W] && !w_r[LANE_W-1];

    assign w_sum[g*LANE_W +: LANE_W] =
        (r_s1_sat && w_pos_ovf) ? {1'b0, {(LANE_W-1){1'b1}}} :
        (r_s1_sat && w_neg_ovf) ? {1'b1, {(LANE_W-1){1'b0}}} :
                                  w_r[LANE_W-1:0];
    assign w_sat[g] = r_s1_sat && (w_pos_ovf || w_neg_ovf);
  end

  // Stage 1 register: capture a new operand pair whenever the stage can load.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are reset along with the valid bit even
      // though only s1_v matters functionally; this keeps the outputs of the
      // datapath defined (X-free) straight out of reset.
      r_s1_v   <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_sub <= 1'b0;
      r_s1_sat <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_a   <= a;
        r_s1_b   <= b;
        r_s1_sub <= sub;
        r_s1_sat <= sat_en;
      end
    end
  end

  // Stage 2 register: take the computed result when stage 2 can load.
  // The data is held while the stage is stalled or drained empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v     <= 1'b0;
      r_sum      <= '0;
      r_sat_lane <= '0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_sum      <= w_sum;
        r_sat_lane <= w_sat;
      end
    end
  end

  // Sticky saturation flags. They accumulate on each delivered result. A clear
  // in the same cycle as a delivery keeps that result's new saturations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_sticky <= '0;
    end else if (clr_sticky) begin
      r_sat_sticky <= w_out_hs ? r_sat_lane : '0;
    end else if (w_out_hs) begin
      r_sat_sticky <= r_sat_sticky | r_sat_lane;
    end
  end

  assign in_ready   = w_s1_load;
  assign out_valid  = r_s2_v;
  assign sum        = r_sum;
  assign sat_lane   = r_sat_lane;
  assign sat_sticky = r_sat_sticky;

endmodule
